// File: rtl/sr_lockstep_checker.sv
// sr_lockstep_checker
// Keeps a golden SR model driven by the same s/r nets as the SR flip-flop
// stage. Each cycle it compares the JK-built (q_jk) and T-built (q_t) outputs
// against that model. Mismatch cycles are flagged and counted. A run of
// MISMATCH_LIMIT consecutive bad cycles latches a sticky fault, which only
// clr_fault can release.
//
// Ports:
//   clk        rising-edge clock, shared with the SR stage
//   rst_n      asynchronous active-low reset
//   en         checking enable (the model tracks s/r even when en is low)
//   s, r       set/reset inputs, the same nets that feed the SR stage
//   q_jk, q_t  SR stage outputs under check
//   clr_fault  one-cycle pulse: clears fault, err_cnt and the consecutive count
//   model_q    golden SR state
//   mismatch   registered: a compare failed on the previous edge
//   illegal_sr registered: s=r=1 was sampled on the previous edge
//   fault      sticky fault flag
//   err_cnt    saturating count of mismatch cycles
module sr_lockstep_checker #(
    parameter int unsigned MISMATCH_LIMIT = 3,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             s,
    input  logic             r,
    input  logic             q_jk,
    input  logic             q_t,
    input  logic             clr_fault,
    output logic             model_q,
    output logic             mismatch,
    output logic             illegal_sr,
    output logic             fault,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, CHECK, SUSPECT, FAULT} state_t;

    localparam logic [4:0] LIMIT = 5'(MISMATCH_LIMIT);

    state_t           state, state_nx;
    logic [3:0]       consec, consec_nx;
    logic [CNT_W-1:0] err_nx;
    logic             bad, mis_cond, limit_hit;

    always_comb begin
        // model_q and the stage outputs move on the same edge, so the
        // pre-edge values are directly comparable.
        bad       = (q_jk != model_q) | (q_t != model_q);
        mis_cond  = (state != FAULT) & en & bad & ~clr_fault;
        limit_hit = ({1'b0, consec} + 5'd1) >= LIMIT;

        state_nx  = state;
        consec_nx = consec;
        err_nx    = err_cnt;

        if (clr_fault) begin
            state_nx  = en ? CHECK : IDLE;
            consec_nx = '0;
            err_nx    = '0;
        end else if (state != FAULT) begin
            // IDLE with en=1 is judged exactly like CHECK, so a mismatch on
            // the enabling edge already starts the consecutive run.
            if (!en) begin
                state_nx  = IDLE;
                consec_nx = '0;
            end else if (mis_cond) begin
                state_nx  = limit_hit ? FAULT : SUSPECT;
                consec_nx = (consec == 4'hF) ? consec : consec + 4'd1;
                if (err_cnt != '1)
                    err_nx = err_cnt + CNT_W'(1);
            end else begin
                state_nx  = CHECK;
                consec_nx = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            consec     <= '0;
            err_cnt    <= '0;
            model_q    <= 1'b0;
            mismatch   <= 1'b0;
            illegal_sr <= 1'b0;
            fault      <= 1'b0;
        end else begin
            unique case ({s, r})
                2'b01:   model_q <= 1'b0;
                2'b10:   model_q <= 1'b1;
                2'b11:   model_q <= ~model_q;
                default: model_q <= model_q;
            endcase
            illegal_sr <= s & r;
            mismatch   <= mis_cond;
            state      <= state_nx;
            consec     <= consec_nx;
            err_cnt    <= err_nx;
            fault      <= (state_nx == FAULT);
        end
    end

endmodule

// File: tb/tb_sr_lockstep_checker.sv
// Bench for sr_lockstep_checker: two instances (LIMIT=3/CNT_W=8 and
// LIMIT=15/CNT_W=2) share the same stimulus and are checked against a
// counter-level reference model after every clock edge.
module tb_sr_lockstep_checker;

    logic clk = 1'b0;
    logic rst_n, en, s, r, q_jk, q_t, clr_fault;
    logic       mq_a, mis_a, ill_a, flt_a;
    logic [7:0] cnt_a;
    logic       mq_b, mis_b, ill_b, flt_b;
    logic [1:0] cnt_b;

    always #5 clk = ~clk;

    sr_lockstep_checker #(.MISMATCH_LIMIT(3), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .q_jk(q_jk), .q_t(q_t),
        .clr_fault(clr_fault), .model_q(mq_a), .mismatch(mis_a),
        .illegal_sr(ill_a), .fault(flt_a), .err_cnt(cnt_a));

    sr_lockstep_checker #(.MISMATCH_LIMIT(15), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .q_jk(q_jk), .q_t(q_t),
        .clr_fault(clr_fault), .model_q(mq_b), .mismatch(mis_b),
        .illegal_sr(ill_b), .fault(flt_b), .err_cnt(cnt_b));

    int n_assert = 0;
    int n_fail   = 0;

    // reference model: one SR state, plus per-instance counters
    bit m_q, m_ill;
    bit m_mis[2], m_flt[2];
    int m_cnt[2], m_con[2];
    int lim[2]  = '{3, 15};
    int cmax[2] = '{255, 3};

    // stimulus knobs for the SR stage outputs
    bit inj_jk, inj_t, stuck_t0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_q = 0; m_ill = 0;
        for (int k = 0; k < 2; k++) begin
            m_mis[k] = 0; m_flt[k] = 0; m_cnt[k] = 0; m_con[k] = 0;
        end
    endtask

    // advance the reference by one edge using the currently driven inputs
    task automatic model_step();
        bit bad;
        bad = (q_jk !== m_q) || (q_t !== m_q);
        for (int k = 0; k < 2; k++) begin
            m_mis[k] = !m_flt[k] && en && bad && !clr_fault;
            if (clr_fault) begin
                m_cnt[k] = 0; m_con[k] = 0; m_flt[k] = 0;
            end else if (!m_flt[k]) begin
                if (m_mis[k]) begin
                    if (m_cnt[k] < cmax[k]) m_cnt[k]++;
                    m_con[k]++;
                    if (m_con[k] >= lim[k]) m_flt[k] = 1;
                end else begin
                    m_con[k] = 0;
                end
            end
        end
        m_ill = s && r;
        if (s && r)  m_q = !m_q;
        else if (s)  m_q = 1;
        else if (r)  m_q = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, " A.model_q"},    {7'd0, mq_a},  {7'd0, m_q});
        chk({tag, " A.mismatch"},   {7'd0, mis_a}, {7'd0, m_mis[0]});
        chk({tag, " A.illegal_sr"}, {7'd0, ill_a}, {7'd0, m_ill});
        chk({tag, " A.fault"},      {7'd0, flt_a}, {7'd0, m_flt[0]});
        chk({tag, " A.err_cnt"},    cnt_a,         8'(m_cnt[0]));
        chk({tag, " B.model_q"},    {7'd0, mq_b},  {7'd0, m_q});
        chk({tag, " B.mismatch"},   {7'd0, mis_b}, {7'd0, m_mis[1]});
        chk({tag, " B.illegal_sr"}, {7'd0, ill_b}, {7'd0, m_ill});
        chk({tag, " B.fault"},      {7'd0, flt_b}, {7'd0, m_flt[1]});
        chk({tag, " B.err_cnt"},    {6'd0, cnt_b}, 8'(m_cnt[1]));
    endtask

    // drive q from the reference state, take one edge, check 1 ns later
    task automatic cyc(input string tag);
        q_jk = m_q ^ inj_jk;
        q_t  = stuck_t0 ? 1'b0 : (m_q ^ inj_t);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic pulse_clr(input string tag);
        clr_fault = 1; cyc(tag); clr_fault = 0;
    endtask

    bit [1:0] sr_seq [6] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b11, 2'b11};
    bit       q_seq  [6] = '{1, 1, 0, 0, 1, 0};
    bit [1:0] sr_v;

    initial begin
        rst_n = 0; en = 0; s = 0; r = 0; clr_fault = 0;
        inj_jk = 0; inj_t = 0; stuck_t0 = 0;
        q_jk = 0; q_t = 0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk); rst_n = 1;

        // basic SR sequence with a correct stage
        en = 1;
        for (int i = 0; i < 6; i++) begin
            sr_v = sr_seq[i]; s = sr_v[1]; r = sr_v[0];
            cyc("sr_seq");
            chk("sr_seq model_q const", {7'd0, mq_a}, {7'd0, q_seq[i]});
        end

        // q_t stuck at 0 while s r = 10 is held
        s = 1; r = 0; stuck_t0 = 1;
        for (int i = 0; i < 5; i++) cyc("stuck_t");
        chk("stuck_t fault const",   {7'd0, flt_a}, 8'd1);
        chk("stuck_t err_cnt const", cnt_a, 8'd3);

        // clear in FAULT with a simultaneous mismatch, then one more bad edge
        pulse_clr("clr_in_fault");
        chk("clr_in_fault err_cnt const", cnt_a, 8'd0);
        cyc("after_clr");
        stuck_t0 = 0;

        // two single-cycle q_jk glitches separated by a good cycle
        pulse_clr("glitch_clr");
        cyc("glitch_pre");
        inj_jk = 1; cyc("glitch1"); inj_jk = 0;
        cyc("glitch_gap");
        inj_jk = 1; cyc("glitch2"); inj_jk = 0;
        cyc("glitch_post");
        chk("glitch err_cnt const", cnt_a, 8'd2);
        chk("glitch fault const",   {7'd0, flt_a}, 8'd0);

        // continuous mismatch: 2-bit counter must saturate, not wrap
        pulse_clr("sat_clr");
        inj_jk = 1;
        for (int i = 0; i < 6; i++) cyc("saturate");
        inj_jk = 0;
        chk("saturate B.err_cnt const", {6'd0, cnt_b}, 8'd3);
        chk("saturate B.fault const",   {7'd0, flt_b}, 8'd0);

        // checking disabled: model still tracks, no mismatches
        pulse_clr("en0_clr");
        en = 0; inj_t = 1; s = 0; r = 1;
        cyc("en0_a"); s = 1; r = 1; cyc("en0_b");
        inj_t = 0; en = 1; s = 0; r = 0;

        // random traffic
        for (int i = 0; i < 300; i++) begin
            s = 1'($urandom); r = 1'($urandom);
            en = ($urandom_range(0, 9) != 0);
            clr_fault = ($urandom_range(0, 24) == 0);
            inj_jk = ($urandom_range(0, 5) == 0);
            inj_t  = ($urandom_range(0, 7) == 0);
            cyc("random");
        end
        clr_fault = 0; inj_jk = 0; inj_t = 0; en = 1;

        // asynchronous reset in SUSPECT with model_q=1
        s = 1; r = 0;
        pulse_clr("pre_rst_clr");
        cyc("pre_rst_set");
        inj_jk = 1; cyc("pre_rst_bad"); inj_jk = 0;
        chk("pre_rst mismatch const", {7'd0, mis_a}, 8'd1);
        #2;
        rst_n = 0;
        model_reset();
        #1;
        check_all("async_rst");
        chk("async_rst model_q const", {7'd0, mq_a}, 8'd0);
        @(posedge clk); #1;
        check_all("rst_held");
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            s = 1'($urandom); r = 1'($urandom);
            cyc("post_rst");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
